// File: rtl/axi_burst_scheduler.sv
// rtl/axi_burst_scheduler.sv - splits write/read jobs into 4 KB-safe AXI bursts, one outstanding at a time
// Optional watchdog on outstanding bursts: define SCHED_TIMEOUT_EN.
module axi_burst_scheduler #(
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int LEN_WIDTH      = 16,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [LEN_WIDTH-1:0]  wr_beats,
  output logic                  wr_ack,
  output logic                  wr_done,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [LEN_WIDTH-1:0]  rd_beats,
  output logic                  rd_ack,
  output logic                  rd_done,
  output logic                  start_write,
  output logic [ID_WIDTH-1:0]   write_id,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [7:0]            write_len,
  output logic [2:0]            write_size,
  output logic [1:0]            write_burst,
  input  logic                  write_complete,
  output logic                  start_read,
  output logic [ID_WIDTH-1:0]   read_id,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [7:0]            read_len,
  output logic [2:0]            read_size,
  output logic [1:0]            read_burst,
  input  logic                  read_complete,
  output logic                  sched_busy,
  output logic                  sched_err
);

  typedef enum logic [2:0] {IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD} state_t;

  state_t                state, state_n;
  logic                  wr_act, rd_act, wr_zero, rd_zero, last_rd;
  logic [ADDR_WIDTH-1:0] wr_cur, rd_cur;
  logic [LEN_WIDTH-1:0]  wr_rem, rd_rem;
  logic [ID_WIDTH-1:0]   seq_id;
  logic [31:0]           beats_q, beats_c, page_lim;
  logic [9:0]            g_page;
  logic [LEN_WIDTH-1:0]  g_rem;
  logic                  grant_wr, grant_rd, wr_cpl, rd_cpl, tmo_hit;

  assign grant_wr = wr_act && (!rd_act || last_rd);
  assign grant_rd = rd_act && !grant_wr;
  assign wr_cpl   = (state == WAIT_WR) && write_complete;
  assign rd_cpl   = (state == WAIT_RD) && read_complete;

  // Burst size is the tightest of remaining beats, MAX_BURST and the beats left in the 4 KB page.
  always_comb begin
    g_page   = grant_wr ? wr_cur[11:2] : rd_cur[11:2];
    g_rem    = grant_wr ? wr_rem : rd_rem;
    page_lim = 32'd1024 - 32'(g_page);
    beats_c  = 32'(g_rem);
    if (32'(MAX_BURST) < beats_c) beats_c = 32'(MAX_BURST);
    if (page_lim < beats_c) beats_c = page_lim;
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = ((state == WAIT_WR && !write_complete) || (state == WAIT_RD && !read_complete))
                   && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt   <= '0;
      sched_err <= 1'b0;
    end else begin
      sched_err <= tmo_hit;
      if (state == WAIT_WR || state == WAIT_RD) tmo_cnt <= tmo_cnt + TW'(1);
      else tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign sched_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (grant_wr) state_n = ISSUE_WR;
                else if (grant_rd) state_n = ISSUE_RD;
      ISSUE_WR: state_n = WAIT_WR;
      WAIT_WR:  if (wr_cpl || tmo_hit) state_n = IDLE;
      ISSUE_RD: state_n = WAIT_RD;
      WAIT_RD:  if (rd_cpl || tmo_hit) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    start_write = (state == ISSUE_WR);
    start_read  = (state == ISSUE_RD);
    sched_busy  = wr_act | rd_act;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_act <= 1'b0; rd_act <= 1'b0; wr_zero <= 1'b0; rd_zero <= 1'b0;
      wr_ack <= 1'b0; rd_ack <= 1'b0; wr_done <= 1'b0; rd_done <= 1'b0;
      wr_cur <= '0; rd_cur <= '0; wr_rem <= '0; rd_rem <= '0;
      last_rd <= 1'b1; seq_id <= '0; beats_q <= '0;
      write_id <= '0; write_addr <= '0; write_len <= '0; write_size <= '0; write_burst <= '0;
      read_id <= '0; read_addr <= '0; read_len <= '0; read_size <= '0; read_burst <= '0;
    end else begin
      wr_ack  <= 1'b0;
      rd_ack  <= 1'b0;
      wr_done <= wr_zero;
      rd_done <= rd_zero;
      wr_zero <= 1'b0;
      rd_zero <= 1'b0;
      // Zero-beat jobs never become active; the pending flag only schedules the done pulse.
      if (wr_req && !wr_act && !wr_zero) begin
        wr_ack <= 1'b1;
        wr_cur <= wr_addr & ~ADDR_WIDTH'(3);
        wr_rem <= wr_beats;
        if (wr_beats == '0) wr_zero <= 1'b1;
        else wr_act <= 1'b1;
      end
      if (rd_req && !rd_act && !rd_zero) begin
        rd_ack <= 1'b1;
        rd_cur <= rd_addr & ~ADDR_WIDTH'(3);
        rd_rem <= rd_beats;
        if (rd_beats == '0) rd_zero <= 1'b1;
        else rd_act <= 1'b1;
      end
      if (state == IDLE && (grant_wr || grant_rd)) begin
        seq_id  <= seq_id + ID_WIDTH'(1);
        last_rd <= grant_rd;
        beats_q <= beats_c;
        if (grant_wr) begin
          write_id <= seq_id; write_addr <= wr_cur; write_len <= 8'(beats_c - 32'd1);
          write_size <= 3'd2; write_burst <= 2'b01;
        end else begin
          read_id <= seq_id; read_addr <= rd_cur; read_len <= 8'(beats_c - 32'd1);
          read_size <= 3'd2; read_burst <= 2'b01;
        end
      end
      if (wr_cpl) begin
        wr_cur <= wr_cur + ADDR_WIDTH'(beats_q * 32'd4);
        wr_rem <= wr_rem - LEN_WIDTH'(beats_q);
        if (wr_rem == LEN_WIDTH'(beats_q)) begin
          wr_act  <= 1'b0;
          wr_done <= 1'b1;
        end
      end
      if (rd_cpl) begin
        rd_cur <= rd_cur + ADDR_WIDTH'(beats_q * 32'd4);
        rd_rem <= rd_rem - LEN_WIDTH'(beats_q);
        if (rd_rem == LEN_WIDTH'(beats_q)) begin
          rd_act  <= 1'b0;
          rd_done <= 1'b1;
        end
      end
      if (tmo_hit && state == WAIT_WR) wr_act <= 1'b0;
      if (tmo_hit && state == WAIT_RD) rd_act <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_burst_scheduler.sv
// tb/tb_axi_burst_scheduler.sv - self-checking bench for axi_burst_scheduler
module tb_axi_burst_scheduler;
  logic clk = 1'b0;
  logic reset;
  logic wr_req, rd_req, wr_ack, wr_done, rd_ack, rd_done;
  logic [31:0] wr_addr, rd_addr, write_addr, read_addr;
  logic [15:0] wr_beats, rd_beats;
  logic start_write, start_read, write_complete, read_complete, sched_busy, sched_err;
  logic [3:0] write_id, read_id;
  logic [7:0] write_len, read_len;
  logic [2:0] write_size, read_size;
  logic [1:0] write_burst, read_burst;

  always #5 clk = ~clk;

  axi_burst_scheduler dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_beats(wr_beats), .wr_ack(wr_ack), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_beats(rd_beats), .rd_ack(rd_ack), .rd_done(rd_done),
    .start_write(start_write), .write_id(write_id), .write_addr(write_addr), .write_len(write_len),
    .write_size(write_size), .write_burst(write_burst), .write_complete(write_complete),
    .start_read(start_read), .read_id(read_id), .read_addr(read_addr), .read_len(read_len),
    .read_size(read_size), .read_burst(read_burst), .read_complete(read_complete),
    .sched_busy(sched_busy), .sched_err(sched_err)
  );

  typedef struct packed {
    logic            is_wr;
    logic [31:0]     addr;
    logic [15:0]     beats;
    logic [1:0]      n;
    logic [2:0][7:0] len;
    logic [2:0][31:0] ba;
  } vec_t;

  typedef struct packed {
    logic        is_wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  vec_t   vecs[6];
  burst_t exp_q[$];
  int compared = 0, mismatched = 0;
  int exp_id = 0;
  int n_wr_done = 0, n_rd_done = 0, n_err = 0, n_start_wr = 0;
  bit resp_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_burst(input logic w, input logic [31:0] a, input logic [7:0] l);
    burst_t b;
    b.is_wr = w; b.id = 4'(exp_id); b.addr = a; b.len = l;
    exp_q.push_back(b);
    exp_id++;
  endtask

  task automatic wait_done(input logic w, input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = w ? wr_done : rd_done;
    end
    check(name, {31'd0, got}, 32'd1);
    check({name, " queue drained"}, exp_q.size(), 0);
    check({name, " busy after done"}, {31'd0, sched_busy}, 32'd0);
  endtask

  // Scoreboard: every start pulse is matched against the oldest expected burst.
  initial begin
    burst_t b;
    forever begin
      @(negedge clk);
      if (wr_done) n_wr_done++;
      if (rd_done) n_rd_done++;
      if (sched_err) n_err++;
      if (start_write) n_start_wr++;
      if (start_write || start_read) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected burst: start_write=%0b start_read=%0b with empty queue", start_write, start_read);
        end else begin
          b = exp_q.pop_front();
          check("burst dir", {31'd0, start_write}, {31'd0, b.is_wr});
          check("burst id", start_write ? write_id : read_id, b.id);
          check("burst addr", start_write ? write_addr : read_addr, b.addr);
          check("burst len", start_write ? write_len : read_len, b.len);
          check("burst size", start_write ? write_size : read_size, 3'd2);
          check("burst type", start_write ? write_burst : read_burst, 2'b01);
        end
      end
    end
  end

  // Memory-master stand-in: completes each burst three cycles after its start pulse.
  initial begin
    logic w;
    write_complete = 1'b0;
    read_complete  = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && (start_write || start_read)) begin
        w = start_write;
        repeat (3) @(negedge clk);
        if (w) write_complete = 1'b1;
        else read_complete = 1'b1;
        @(negedge clk);
        write_complete = 1'b0;
        read_complete  = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic a;
    int snap, exp_err, exp_busy;
    vecs[0] = '{1'b1, 32'h0,    16'd40, 2'd3, {8'd7, 8'd15, 8'd15}, {32'h80, 32'h40, 32'h0}};
    vecs[1] = '{1'b0, 32'hFF8,  16'd8,  2'd2, {8'd0, 8'd5,  8'd1},  {32'h0, 32'h1000, 32'hFF8}};
    vecs[2] = '{1'b1, 32'h103,  16'd5,  2'd1, {8'd0, 8'd0,  8'd4},  {32'h0, 32'h0, 32'h100}};
    vecs[3] = '{1'b0, 32'h1FC0, 16'd20, 2'd2, {8'd0, 8'd3,  8'd15}, {32'h0, 32'h2000, 32'h1FC0}};
    vecs[4] = '{1'b1, 32'hFFC,  16'd3,  2'd2, {8'd0, 8'd1,  8'd0},  {32'h0, 32'h1000, 32'hFFC}};
    vecs[5] = '{1'b0, 32'h10,   16'd16, 2'd1, {8'd0, 8'd0,  8'd15}, {32'h0, 32'h0, 32'h10}};

    reset = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_beats = '0; rd_beats = '0;
    repeat (3) @(negedge clk);
    check("reset start_write", {31'd0, start_write}, 32'd0);
    check("reset write_addr", write_addr, 32'd0);
    check("reset write_size", {29'd0, write_size}, 32'd0);
    check("reset sched_busy", {31'd0, sched_busy}, 32'd0);
    check("reset sched_err", {31'd0, sched_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Both sides at once: alternate W,R,W,R with ids 0..3.
    wr_req = 1'b1; wr_addr = 32'h0;    wr_beats = 16'd32;
    rd_req = 1'b1; rd_addr = 32'h2000; rd_beats = 16'd32;
    push_burst(1'b1, 32'h0, 8'd15);
    push_burst(1'b0, 32'h2000, 8'd15);
    push_burst(1'b1, 32'h40, 8'd15);
    push_burst(1'b0, 32'h2040, 8'd15);
    snap = n_wr_done;
    @(negedge clk);
    check("dual wr_ack", {31'd0, wr_ack}, 32'd1);
    check("dual rd_ack", {31'd0, rd_ack}, 32'd1);
    check("dual busy", {31'd0, sched_busy}, 32'd1);
    wr_req = 1'b0; rd_req = 1'b0;
    wait_done(1'b0, "dual rd_done");
    check("dual wr_done count", n_wr_done - snap, 1);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vecs[i].is_wr) begin
        wr_req = 1'b1; wr_addr = vecs[i].addr; wr_beats = vecs[i].beats;
      end else begin
        rd_req = 1'b1; rd_addr = vecs[i].addr; rd_beats = vecs[i].beats;
      end
      for (int k = 0; k < int'(vecs[i].n); k++) push_burst(vecs[i].is_wr, vecs[i].ba[k], vecs[i].len[k]);
      @(negedge clk);
      a = vecs[i].is_wr ? wr_ack : rd_ack;
      check($sformatf("vec%0d ack", i), {31'd0, a}, 32'd1);
      wr_req = 1'b0; rd_req = 1'b0;
      @(negedge clk);
      a = vecs[i].is_wr ? wr_ack : rd_ack;
      check($sformatf("vec%0d ack single", i), {31'd0, a}, 32'd0);
      wait_done(vecs[i].is_wr, $sformatf("vec%0d done", i));
    end

    // Zero-beat job: ack, done next cycle, no burst.
    @(negedge clk);
    snap = n_start_wr;
    wr_req = 1'b1; wr_addr = 32'h800; wr_beats = 16'd0;
    @(negedge clk);
    check("zero ack", {31'd0, wr_ack}, 32'd1);
    check("zero done early", {31'd0, wr_done}, 32'd0);
    wr_req = 1'b0;
    @(negedge clk);
    check("zero done", {31'd0, wr_done}, 32'd1);
    @(negedge clk);
    check("zero done single", {31'd0, wr_done}, 32'd0);
    repeat (3) @(negedge clk);
    check("zero no burst", n_start_wr - snap, 0);

    // Stray completions while idle are ignored.
    snap = n_wr_done + n_rd_done;
    write_complete = 1'b1; read_complete = 1'b1;
    @(negedge clk);
    write_complete = 1'b0; read_complete = 1'b0;
    repeat (2) @(negedge clk);
    check("stray busy", {31'd0, sched_busy}, 32'd0);
    check("stray done", n_wr_done + n_rd_done - snap, 0);

    // Accept a new job in the cycle the previous one reports done.
    wr_req = 1'b1; wr_addr = 32'h300; wr_beats = 16'd4;
    push_burst(1'b1, 32'h300, 8'd3);
    @(negedge clk);
    wr_req = 1'b0;
    wait_done(1'b1, "b2b first done");
    wr_req = 1'b1; wr_addr = 32'h400; wr_beats = 16'd2;
    push_burst(1'b1, 32'h400, 8'd1);
    @(negedge clk);
    check("b2b ack", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    wait_done(1'b1, "b2b second done");

    // Read burst never completed.
    resp_en = 1'b0;
    snap = n_rd_done;
    rd_req = 1'b1; rd_addr = 32'h500; rd_beats = 16'd4;
    push_burst(1'b0, 32'h500, 8'd3);
    @(negedge clk);
    rd_req = 1'b0;
    repeat (1100) @(negedge clk);
`ifdef SCHED_TIMEOUT_EN
    exp_err = 1; exp_busy = 0;
`else
    exp_err = 0; exp_busy = 1;
`endif
    check("hang sched_err pulses", n_err, exp_err);
    check("hang busy", {31'd0, sched_busy}, 32'(exp_busy));
    check("hang no rd_done", n_rd_done - snap, 0);
    check("hang burst issued", exp_q.size(), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_id = 0;

    // Reset while a write burst is outstanding.
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 32'h600; wr_beats = 16'd8;
    push_burst(1'b1, 32'h600, 8'd7);
    @(negedge clk);
    wr_req = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset busy", {31'd0, sched_busy}, 32'd1);
    check("pre-reset write_addr", write_addr, 32'h600);
    #2 reset = 1'b1;
    #1;
    check("async reset write_addr", write_addr, 32'd0);
    check("async reset write_len", {24'd0, write_len}, 32'd0);
    check("async reset busy", {31'd0, sched_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    snap = n_wr_done;
    repeat (5) @(negedge clk);
    check("reset no wr_done", n_wr_done - snap, 0);
    resp_en = 1'b1;
    exp_q.delete();
    exp_id = 0;
    wr_req = 1'b1; wr_addr = 32'h700; wr_beats = 16'd4;
    push_burst(1'b1, 32'h700, 8'd3);
    @(negedge clk);
    check("post-reset ack", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    wait_done(1'b1, "post-reset done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
